// File: rtl/display_scan_if.sv
// Bundles the digit-load inputs and the scanned display outputs of display_scan_mux.
// master drives loads and samples the display; slave is the scanner itself.
interface display_scan_if #(
  parameter int NUM_DIGITS = 4
);
  logic                      load;
  logic [4*NUM_DIGITS-1:0]   digits_in;
  logic                      lz_blank_en;
  logic [3:0]                bcd_out;
  logic [NUM_DIGITS-1:0]     digit_en;
  logic                      frame_done;

  modport master (
    output load, digits_in, lz_blank_en,
    input  bcd_out, digit_en, frame_done
  );

  modport slave (
    input  load, digits_in, lz_blank_en,
    output bcd_out, digit_en, frame_done
  );
endinterface

// File: rtl/display_scan_mux.sv
// Time-multiplexed 7-segment digit scanner with double-buffered digit values,
// per-slot anti-ghosting guard time and optional leading-zero blanking.
module display_scan_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 2,
  parameter int DIG_ACT_LOW  = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  display_scan_if.slave  bus
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DW = 4 * NUM_DIGITS;

  typedef enum logic {GUARD, ON} phase_t;
  localparam phase_t PHASE_RST = (BLANK_CYCLES > 0) ? GUARD : ON;
  localparam logic [NUM_DIGITS-1:0] EN_OFF = (DIG_ACT_LOW != 0) ? '1 : '0;

  logic [CW-1:0]         div_cnt_reg, div_cnt_next;
  logic [IW-1:0]         idx_reg, idx_next;
  phase_t                phase_reg, phase_next;
  logic [DW-1:0]         active_reg, pending_reg;
  logic                  pend_vld_reg;
  logic [3:0]            bcd_out_reg, bcd_out_next;
  logic [NUM_DIGITS-1:0] digit_en_reg, digit_en_next;
  logic                  frame_done_reg;

  logic                  wrap, boundary;
  logic [NUM_DIGITS:1]   upper_zero;
  logic [NUM_DIGITS-1:0] blanked;
  logic [NUM_DIGITS-1:0] onehot;
  logic [3:0]            sel_digit;

  assign wrap     = (div_cnt_reg == CW'(CLK_DIV - 1));
  assign boundary = wrap && (idx_reg == IW'(NUM_DIGITS - 1));

  // upper_zero[i]: digits i..NUM_DIGITS-1 of the shown value are all zero
  assign upper_zero[NUM_DIGITS] = 1'b1;
  assign blanked[0]             = 1'b0;
  generate
    for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
      assign upper_zero[gi] = upper_zero[gi+1] && (active_reg[4*gi +: 4] == 4'h0);
      assign blanked[gi]    = bus.lz_blank_en && upper_zero[gi];
    end
  endgenerate

  assign sel_digit = active_reg[idx_reg*4 +: 4];
  assign onehot    = NUM_DIGITS'(1) << idx_reg;

  // Next-state: slot counter, digit index and the slot phase that goes with them
  always_comb begin
    div_cnt_next = wrap ? '0 : div_cnt_reg + 1'b1;
    idx_next     = idx_reg;
    if (wrap) begin
      idx_next = boundary ? '0 : idx_reg + 1'b1;
    end
    phase_next = ON;
    if ((BLANK_CYCLES > 0) && (div_cnt_next < CW'(BLANK_CYCLES))) begin
      phase_next = GUARD;
    end
  end

  // Output decode from the current phase; registered below, hence one cycle of lag
  always_comb begin
    bcd_out_next  = 4'hF;
    digit_en_next = EN_OFF;
    if (phase_reg == ON) begin
      digit_en_next = (DIG_ACT_LOW != 0) ? ~onehot : onehot;
      bcd_out_next  = blanked[idx_reg] ? 4'hF : sel_digit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_reg    <= '0;
      idx_reg        <= '0;
      phase_reg      <= PHASE_RST;
      active_reg     <= '0;
      pending_reg    <= '0;
      pend_vld_reg   <= 1'b0;
      bcd_out_reg    <= 4'hF;
      digit_en_reg   <= EN_OFF;
      frame_done_reg <= 1'b0;
    end else begin
      div_cnt_reg    <= div_cnt_next;
      idx_reg        <= idx_next;
      phase_reg      <= phase_next;
      bcd_out_reg    <= bcd_out_next;
      digit_en_reg   <= digit_en_next;
      frame_done_reg <= boundary;
      // Transfer uses the old pending value; a same-cycle load re-arms the buffer
      if (boundary && pend_vld_reg) begin
        active_reg   <= pending_reg;
        pend_vld_reg <= 1'b0;
      end
      if (bus.load) begin
        pending_reg  <= bus.digits_in;
        pend_vld_reg <= 1'b1;
      end
    end
  end

  assign bus.bcd_out    = bcd_out_reg;
  assign bus.digit_en   = digit_en_reg;
  assign bus.frame_done = frame_done_reg;
endmodule

// File: tb/tb_display_scan_mux.sv
// Randomized scoreboard bench for display_scan_mux: a frame-level model predicts every
// output cycle, a separate monitor pops and compares on each falling clock edge.
module tb_display_scan_mux;
  localparam int ND    = 4;
  localparam int DIV   = 8;
  localparam int BLANK = 2;
  localparam int FRAME = ND * DIV;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] en;
    logic       fd;
  } exp_t;

  logic clk;
  logic rst_n;
  display_scan_if #(.NUM_DIGITS(ND)) bus ();

  display_scan_mux #(
    .NUM_DIGITS(ND), .CLK_DIV(DIV), .BLANK_CYCLES(BLANK), .DIG_ACT_LOW(1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  exp_t        exp_q[$];
  int          m_cyc;
  logic [15:0] m_active, m_pending;
  bit          m_pvld;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: position inside the frame is plain cycle arithmetic since reset
  initial begin
    m_cyc = 0; m_active = '0; m_pending = '0; m_pvld = 0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_cyc = 0; m_active = '0; m_pending = '0; m_pvld = 0;
        exp_q.delete();
      end else begin
        int   pos, slot, ph;
        exp_t e;
        pos  = m_cyc % FRAME;
        slot = pos / DIV;
        ph   = pos % DIV;
        e.fd = (pos == FRAME - 1);
        if (ph < BLANK) begin
          e.bcd = 4'hF;
          e.en  = 4'b1111;
        end else begin
          e.en  = ~(4'b0001 << slot);
          e.bcd = m_active[4*slot +: 4];
          if (bus.lz_blank_en && slot > 0 && (m_active >> (4*slot)) == 16'h0)
            e.bcd = 4'hF;
        end
        exp_q.push_back(e);
        if (pos == FRAME - 1 && m_pvld) begin
          m_active = m_pending;
          m_pvld   = 0;
        end
        if (bus.load) begin
          m_pending = bus.digits_in;
          m_pvld    = 1;
        end
        m_cyc++;
      end
    end
  end

  // Monitor: reset values while held, otherwise the oldest prediction
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n_checks++;
        if (bus.bcd_out !== 4'hF || bus.digit_en !== 4'b1111 || bus.frame_done !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_hold: got bcd=%h en=%b fd=%b, want bcd=f en=1111 fd=0",
                   bus.bcd_out, bus.digit_en, bus.frame_done);
        end
      end else if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        n_checks++;
        if (bus.bcd_out !== e.bcd || bus.digit_en !== e.en || bus.frame_done !== e.fd) begin
          n_fail++;
          $display("FAIL scan t=%0t: got bcd=%h en=%b fd=%b, want bcd=%h en=%b fd=%b",
                   $time, bus.bcd_out, bus.digit_en, bus.frame_done, e.bcd, e.en, e.fd);
        end
      end
    end
  end

  task automatic tick(input logic ld, input logic [15:0] d);
    @(negedge clk);
    #1;
    bus.load      = ld;
    bus.digits_in = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(1'b0, bus.digits_in);
  endtask

  // Strobe load so that the DUT samples it at frame position p
  task automatic load_at(input int p, input logic [15:0] d);
    int k;
    k = 0;
    while ((m_cyc % FRAME) != p && k < 2 * FRAME) begin
      tick(1'b0, bus.digits_in);
      k++;
    end
    n_checks++;
    if ((m_cyc % FRAME) != p) begin
      n_fail++;
      $display("FAIL load_at_timeout: got pos=%0d, want pos=%0d", m_cyc % FRAME, p);
    end
    bus.load      = 1'b1;
    bus.digits_in = d;
    tick(1'b0, d);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int i = 0; i < ND; i++)
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    if ($urandom_range(0, 3) == 0) v[15:8] = 8'h00;
    return v;
  endfunction

  initial begin
    rst_n           = 1'b0;
    bus.load        = 1'b0;
    bus.digits_in   = '0;
    bus.lz_blank_en = 1'b0;
    idle(4);
    rst_n = 1'b1;

    // Basic scan of 1234, no blanking
    load_at(5, 16'h1234);
    idle(2 * FRAME + 10);

    // Leading-zero blanking on and off
    load_at(3, 16'h0050);
    bus.lz_blank_en = 1'b1;
    idle(2 * FRAME);
    bus.lz_blank_en = 1'b0;
    idle(FRAME);

    // Load during slot 1 of a frame showing 1234
    load_at(3, 16'h1234);
    idle(FRAME);
    load_at(DIV, 16'h9999);
    idle(2 * FRAME);

    // Load on the boundary cycle while another value is pending
    load_at(10, 16'hAAAA);
    load_at(FRAME - 1, 16'h5678);
    idle(2 * FRAME + 4);

    // Asynchronous reset mid-ON of digit 2 with a load pending
    load_at(4, 16'h4321);
    idle(FRAME);
    bus.lz_blank_en = 1'b1;
    load_at(2 * DIV + 1, 16'h8765);
    idle(1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.bcd_out !== 4'hF || bus.digit_en !== 4'b1111 || bus.frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got bcd=%h en=%b fd=%b, want bcd=f en=1111 fd=0",
               bus.bcd_out, bus.digit_en, bus.frame_done);
    end
    idle(3);
    rst_n = 1'b1;
    idle(2 * FRAME);

    // Randomized loads and blanking changes
    for (int k = 0; k < 2000; k++) begin
      if ($urandom_range(0, 99) == 0) bus.lz_blank_en = ~bus.lz_blank_en;
      tick(($urandom_range(0, 19) == 0), rand_digits());
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
